// File: rtl/uart_rx_frame_loader.sv
// 8N1 UART receiver on a shared 16x oversampling tick; streams received bytes into a frame RAM.
// Optional build macro UART_RX_SYNC_EN: frames start after SYNC_BYTE and a framing error aborts the frame.
module uart_rx_frame_loader #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    IMG_WIDTH    = 176,
  parameter int                    IMG_HEIGHT   = 240,
  parameter int                    TOTAL_PIXELS = IMG_WIDTH * IMG_HEIGHT,
  parameter int                    ADDR_WIDTH   = $clog2(TOTAL_PIXELS),
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  b_16tick,
  input  logic                  rx,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wAddr,
  output logic [DATA_WIDTH-1:0] wData,
  output logic                  frame_done,
  output logic                  rx_err
);

  localparam int                    BW       = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0]         LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(TOTAL_PIXELS - 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_st_t;

`ifdef UART_RX_SYNC_EN
  typedef enum logic [1:0] {F_WAIT_SYNC, F_LOAD, F_DONE} frm_st_t;
  localparam frm_st_t F_INIT = F_WAIT_SYNC;
`else
  typedef enum logic [1:0] {F_LOAD, F_DONE} frm_st_t;
  localparam frm_st_t F_INIT = F_LOAD;
`endif

  logic                  rx_s1, rx_q;
  bit_st_t               bst;
  logic [3:0]            tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  byte_valid;
  frm_st_t               fst;
  logic [ADDR_WIDTH-1:0] pix_cnt;

  // rx is asynchronous; idle level is high so the synchroniser resets high
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_q  <= rx_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bst        <= B_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      rx_err     <= 1'b0;
      case (bst)
        B_IDLE: if (!rx_q) begin
          bst      <= B_START;
          tick_cnt <= '0;
        end
        // mid-start-bit check rejects glitches shorter than half a bit
        B_START: if (b_16tick) begin
          if (tick_cnt == 4'd7) begin
            if (rx_q) bst <= B_IDLE;
            else begin
              bst      <= B_DATA;
              tick_cnt <= '0;
              bit_cnt  <= '0;
            end
          end else tick_cnt <= tick_cnt + 4'd1;
        end
        B_DATA: if (b_16tick) begin
          tick_cnt <= tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            shreg   <= {rx_q, shreg[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) bst <= B_STOP;
          end
        end
        B_STOP: if (b_16tick) begin
          tick_cnt <= tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            if (rx_q) byte_valid <= 1'b1;
            else      rx_err     <= 1'b1;
            bst <= B_IDLE;
          end
        end
        default: bst <= B_IDLE;
      endcase
    end
  end

  // shreg stays stable until the next byte's data bits, so it doubles as the byte register
  always_ff @(posedge clk) begin
    if (!reset) begin
      fst        <= F_INIT;
      pix_cnt    <= '0;
      we         <= 1'b0;
      wAddr      <= '0;
      wData      <= '0;
      frame_done <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      case (fst)
`ifdef UART_RX_SYNC_EN
        F_WAIT_SYNC: if (byte_valid && shreg == SYNC_BYTE) fst <= F_LOAD;
`endif
        F_LOAD: begin
`ifdef UART_RX_SYNC_EN
          if (rx_err) begin
            fst     <= F_WAIT_SYNC;
            pix_cnt <= '0;
          end else
`endif
          if (byte_valid) begin
            we    <= 1'b1;
            wAddr <= pix_cnt;
            wData <= shreg;
            if (pix_cnt == LAST_PIX) fst <= F_DONE;
            else                     pix_cnt <= pix_cnt + 1'b1;
          end
        end
        F_DONE: begin
          frame_done <= 1'b1;
          pix_cnt    <= '0;
          fst        <= F_INIT;
        end
        default: fst <= F_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_loader.sv
// Directed bench for uart_rx_frame_loader: 4x2 frame, tick every 4 clks, 64 clks per UART bit.
// Build with +define+UART_RX_SYNC_EN to exercise the sync-header variant.
module tb_uart_rx_frame_loader;
  localparam int DW = 8, IW = 4, IH = 2, AW = 3;

  logic          clk = 1'b0, reset = 1'b0, b_16tick = 1'b0, rx = 1'b1;
  logic          we, frame_done, rx_err;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] wData;

  int k = 0, k0 = 0, n_chk = 0, n_fail = 0;
  int wr_k[$], wr_a[$], wr_d[$], fd_k[$], er_k[$];

  always #5 clk = ~clk;

  uart_rx_frame_loader #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
    .clk(clk), .reset(reset), .b_16tick(b_16tick), .rx(rx),
    .we(we), .wAddr(wAddr), .wData(wData), .frame_done(frame_done), .rx_err(rx_err)
  );

  always @(posedge clk) begin
    #1;
    if (we) begin
      wr_k.push_back(k);
      wr_a.push_back(int'(wAddr));
      wr_d.push_back(int'(wData));
    end
    if (frame_done) fd_k.push_back(k);
    if (rx_err)     er_k.push_back(k);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  // every stimulus change happens at a negedge; k indexes the posedge that follows
  task automatic step();
    @(negedge clk);
    k++;
    b_16tick = (k % 4 == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin step(); rx = 1'b1; end
  endtask

  task automatic clear_q();
    wr_k.delete(); wr_a.delete(); wr_d.delete(); fd_k.delete(); er_k.delete();
  endtask

  // start bit begins at k0 with k0%4==1, so the stop-sample tick lands at k0+607
  task automatic send_byte(input logic [7:0] b, input bit good);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    while (k % 4 != 0) step();
    for (int j = 0; j < 10; j++)
      for (int s = 0; s < 64; s++) begin
        step();
        if (j == 0 && s == 0) k0 = k;
        rx = fr[j];
        if (j == 9 && !good && s < 40) rx = 1'b0;
      end
  endtask

  task automatic do_reset(input bit toggle);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (toggle) rx = k[0];
    end
    rx = 1'b1;
    step();
    reset = 1'b1;
    idle(4);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_waddr"}, wAddr, 0);
    chk({tag, "_wdata"}, wData, 0);
    chk({tag, "_fdone"}, frame_done, 0);
    chk({tag, "_rxerr"}, rx_err, 0);
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int i = 0; i < 8; i++) send_byte(base + 8'(i), 1'b1);
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] base);
    chk({tag, "_cnt"}, wr_k.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), at(wr_a, i), i);
      chk($sformatf("%s_data%0d", tag, i), at(wr_d, i), int'(base) + i);
    end
    chk({tag, "_fd_cnt"}, fd_k.size(), 1);
    chk({tag, "_fd_lat"}, at(fd_k, 0), at(wr_k, 7) + 1);
  endtask

  initial begin
    int stop_k0;

    do_reset(1'b1);
    chk_idle_outs("rst");
    idle(20);
    chk("rst_nowe", wr_k.size(), 0);

`ifndef UART_RX_SYNC_EN
    clear_q();
    send_byte(8'h3C, 1'b1);
    stop_k0 = k0;
    idle(16);
    chk("one_cnt", wr_k.size(), 1);
    chk("one_addr", at(wr_a, 0), 0);
    chk("one_data", at(wr_d, 0), 8'h3C);
    chk("one_lat", at(wr_k, 0), stop_k0 + 608);
    chk("one_hold_addr", wAddr, 0);
    chk("one_hold_data", wData, 8'h3C);

    do_reset(1'b0);
    clear_q();
    send_frame(8'h00);
    idle(16);
    chk_frame("frm", 8'h00);
    send_byte(8'h55, 1'b1);
    idle(16);
    chk("wrap_addr", at(wr_a, 8), 0);
    chk("wrap_data", at(wr_d, 8), 8'h55);

    // low pulse just under half a bit: must be rejected as a false start
    clear_q();
    while (k % 4 != 0) step();
    repeat (28) begin step(); rx = 1'b0; end
    idle(700);
    chk("glitch_we", wr_k.size(), 0);
    chk("glitch_err", er_k.size(), 0);

    send_byte(8'h81, 1'b0);
    stop_k0 = k0;
    idle(40);
    chk("ferr_cnt", er_k.size(), 1);
    chk("ferr_lat", at(er_k, 0), stop_k0 + 607);
    chk("ferr_we", wr_k.size(), 0);
    send_byte(8'h42, 1'b1);
    idle(16);
    chk("after_err_addr", at(wr_a, 0), 1);
    chk("after_err_data", at(wr_d, 0), 8'h42);
`else
    clear_q();
    send_byte(8'h11, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_frame(8'h20);
    idle(16);
    chk_frame("sfrm", 8'h20);

    clear_q();
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i), 1'b1);
    send_byte(8'h81, 1'b0);
    idle(40);
    send_byte(8'h33, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h77, 1'b1);
    idle(16);
    chk("abort_err", er_k.size(), 1);
    chk("abort_fd", fd_k.size(), 0);
    chk("abort_cnt", wr_k.size(), 4);
    chk("abort_addr2", at(wr_a, 2), 2);
    chk("restart_addr", at(wr_a, 3), 0);
    chk("restart_data", at(wr_d, 3), 8'h77);
`endif

    // reset mid-frame and mid-byte
    do_reset(1'b0);
    clear_q();
`ifdef UART_RX_SYNC_EN
    send_byte(8'hA5, 1'b1);
`endif
    for (int i = 0; i < 5; i++) send_byte(8'hB0 + 8'(i), 1'b1);
    chk("mid_pre_addr", wAddr, 4);
    chk("mid_pre_data", wData, 8'hB4);
    repeat (200) begin step(); rx = 1'b0; end
    do_reset(1'b0);
    chk_idle_outs("mid_rst");
    idle(20);
    clear_q();
`ifdef UART_RX_SYNC_EN
    send_byte(8'hA5, 1'b1);
`endif
    send_byte(8'h99, 1'b1);
    idle(16);
    chk("mid_next_cnt", wr_k.size(), 1);
    chk("mid_next_addr", at(wr_a, 0), 0);
    chk("mid_next_data", at(wr_d, 0), 8'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame_loader.md
# uart_rx_frame_loader

Receive side of the PC↔FPGA UART link. Deserialises 8N1 bytes from the `rx` pin using the shared 16× oversampling tick, assembles them into one grayscale image frame of `IMG_WIDTH*IMG_HEIGHT` bytes, and writes each byte into the input frame RAM through a simple write port. Pulses `frame_done` when the last pixel of a frame has been written, so the image pipeline can start processing.

## Interface
- `DATA_WIDTH`, 8: bits per UART byte and per pixel.
- `IMG_WIDTH`, 176: pixels per line.
- `IMG_HEIGHT`, 240: lines per frame.
- `TOTAL_PIXELS`, `IMG_WIDTH*IMG_HEIGHT`: bytes per frame.
- `ADDR_WIDTH`, `$clog2(TOTAL_PIXELS)`: RAM address width.
- `SYNC_BYTE`, 8'hA5: frame header value, used only with `UART_RX_SYNC_EN`.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-low.
- `b_16tick` in 1: one-cycle strobe at 16× the baud rate, from the shared tick generator.
- `rx` in 1: serial input, asynchronous, idle high.
- `we` out 1: RAM write enable, one-cycle pulse per pixel.
- `wAddr` out `ADDR_WIDTH`: RAM write address, 0..`TOTAL_PIXELS`-1.
- `wData` out `DATA_WIDTH`: pixel byte.
- `frame_done` out 1: one-cycle pulse after the last pixel write.
- `rx_err` out 1: one-cycle pulse on a framing error.

## Operation
- Input synchroniser: 2-FF synchroniser on `rx`. Both flops reset to 1.
- Bit FSM:
  - States are IDLE, START, DATA, STOP. A 4-bit tick counter and a 3-bit bit counter advance only on `b_16tick`.
  - IDLE: a synchronised low moves to START with the tick counter cleared.
  - START: on tick count 7, sample the line. If it is high, this is a false start: return to IDLE, no output. If it is low, clear the tick counter and go to DATA.
  - DATA: on every tick count 15, shift in the sample LSB-first. After 8 bits, go to STOP.
  - STOP: on tick count 15, sample the line.
    - High: internal `byte_valid` pulses with the byte.
    - Low: `rx_err` pulses and the byte is discarded.
    - In both cases return to IDLE.
- Frame FSM:
  - States are WAIT_SYNC, LOAD, DONE. WAIT_SYNC exists only with the macro.
  - LOAD: each `byte_valid` produces `we`=1, `wData`=byte, `wAddr`=pixel counter, and the counter increments after the write.
  - When the write at address `TOTAL_PIXELS-1` occurs, go to DONE.
  - DONE: pulse `frame_done` for one cycle. Clear the pixel counter to 0. Return to WAIT_SYNC with the macro, or LOAD without it.
  - The pixel counter never exceeds `TOTAL_PIXELS-1`. Wrap is explicit via DONE, not modulo 2^`ADDR_WIDTH`.
- A framing error does not advance `wAddr`.
- Reset, any state, mid-byte or mid-frame:
  - Bit FSM returns to IDLE.
  - Frame FSM returns to its initial state (WAIT_SYNC with the macro, LOAD without it).
  - Counters clear to 0.
  - The partial frame is abandoned. RAM contents are not cleared.

## Timing
- Reset values: `we`=0, `wAddr`=0, `wData`=0, `frame_done`=0, `rx_err`=0.
- `byte_valid` or `rx_err` asserts in the clk cycle after the `b_16tick` that sampled the stop bit.
- `we`, `wAddr`, `wData` are registered and assert 1 clk after `byte_valid`, i.e. 2 clks after the stop-sample tick.
- `wAddr` and `wData` hold their values until the next write.
- `frame_done` asserts exactly 1 clk after the final `we`.
- Sampling points fall at tick 7 of the start bit, then every 16 ticks. This tolerates ±~3% baud mismatch.
- Back-to-back bytes with no idle gap are accepted: a START can begin in the same cycle the FSM returns to IDLE if the line is low.
- No backpressure: the RAM must accept one write per byte period.

## Configuration
- `UART_RX_SYNC_EN` defined:
  - A frame starts only after a byte equal to `SYNC_BYTE` is received in WAIT_SYNC. Other bytes in WAIT_SYNC are dropped and produce no `we`.
  - The sync byte itself is not written.
  - An `rx_err` during LOAD aborts the frame: return to WAIT_SYNC, counter to 0, no `frame_done`.
- `UART_RX_SYNC_EN` undefined:
  - Every valid byte is a pixel, starting at address 0 after reset.
  - `rx_err` only drops the byte; loading continues.

## Test plan
All scenarios use `IMG_WIDTH`=4, `IMG_HEIGHT`=2 (8 pixels) and `b_16tick` every 4 clks.
- Reset held low 5 clks with `rx` toggling, then released -> all outputs 0, no `we`.
- Byte 8'h3C sent 8N1 (no macro) -> one `we` with `wAddr`=0, `wData`=8'h3C, exactly 2 clks after the stop-sample tick.
- Bytes 0x00..0x07 sent back-to-back (no macro) -> 8 writes to addresses 0..7 with matching data, `frame_done` 1 clk after the 8th `we`; a 9th byte 0x55 writes to `wAddr`=0.
- 0.5-bit low glitch on `rx` -> no `we`, no `rx_err`. Byte 0x81 sent with the stop bit forced low -> `rx_err` pulse, no `we`, next good byte still written to the same address.
- With `UART_RX_SYNC_EN`: 0x11, then 0xA5, then 8 pixels -> 0x11 and 0xA5 are not written, pixels go to 0..7, then `frame_done`. A framing error after the 3rd pixel -> no `frame_done`, and the next 0xA5 restarts at `wAddr`=0.
- `reset` asserted after the 5th pixel of a frame -> outputs return to 0, and the next frame starts at `wAddr`=0.
